matmul_result_streamer: RTL and testbench
=========================================

// Module: matmul_result_streamer
// PURPOSE
//  Downstream stage of the matmul core. Captures the ROWSxCOLS signed result matrix C when the core pulses done.
//  Serialises C row-major onto an AXI4-Stream master, one element per beat, with tlast on the final element.
//  Feeds the accelerator's AXI output path. Supports a per-element width reduction to OUT_W.
// PARAMETERS
//  ACC_W  32  width of each C element from the core (signed)
//  OUT_W  32  stream tdata width; must satisfy OUT_W <= ACC_W
//  ROWS   2   rows of C
//  COLS   2   columns of C
// PORTS
//  clk            in   1                 clock; all logic on posedge
//  rst_n          in   1                 synchronous active-low reset
//  done           in   1                 core result-valid pulse; C is valid in the same cycle
//  C              in   ACC_W x[ROWS][COLS]  signed result matrix from the core
//  m_axis_tvalid  out  1                 stream beat valid
//  m_axis_tready  in   1                 downstream ready
//  m_axis_tdata   out  OUT_W             element, row-major: C[0][0], C[0][1], ...
//  m_axis_tlast   out  1                 high on the beat carrying C[ROWS-1][COLS-1]
//  busy           out  1                 high while a matrix is held or streaming
//  overrun        out  1                 sticky: done arrived while busy, so that result was dropped
//  err_clr        in   1                 clears overrun (1-cycle pulse)
//  sat_flag       out  1                 sticky: an element was saturated (RESULT_SAT_EN only)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, idx=0, tvalid=0, tlast=0, tdata=0, busy=0, overrun=0, sat_flag=0.
//  FSM states IDLE and STREAM.
//  IDLE: on done=1, latch all of C into the holding buffer, set idx=0, go to STREAM. done=0: stay.
//  STREAM: tvalid=1, tdata=elem(buf[idx/COLS][idx%COLS]), tlast=(idx==ROWS*COLS-1), busy=1.
//  Latency: done in cycle N gives first tvalid in cycle N+1. Full throughput is 1 beat/cycle with tready held high.
//  Handshake: a beat transfers when tvalid&tready. On transfer, idx increments.
//  AXI rule: while tvalid&!tready, tdata and tlast stay stable. tvalid never drops before its beat transfers.
//  Last beat transfers (tlast&tready): if done=1 in the same cycle, capture the new C, set idx=0, stay STREAM (back-to-back).
//    Otherwise idx=0 and go to IDLE.
//  done in STREAM at any other time: the new C is ignored, the buffer is unchanged, overrun<=1.
//  err_clr=1 clears overrun. If err_clr and a new overrun occur in the same cycle, overrun stays 1 (set wins).
//  idx width is clog2(ROWS*COLS). idx never exceeds ROWS*COLS-1; it wraps only through the last-beat transfer.
//  Reset mid-stream abandons the matrix immediately; no tlast is issued for it.
//  X on C while done=0 has no effect on any output.
// CONFIGURATION
//  Macro RESULT_SAT_EN.
//  Defined: elem(x) saturates signed x to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    sat_flag<=1 when a transferred beat was clamped; it is sticky and cleared by err_clr or reset.
//  Undefined: elem(x) = x[OUT_W-1:0] (plain truncation). sat_flag is tied to 0.
//  When OUT_W==ACC_W both builds produce identical tdata.
// TESTING
//  T1 A={{1,2},{3,4}}, B={{5,6},{7,8}}, done with C={{19,22},{43,50}}, tready=1
//     -> beats 19,22,43,50 on 4 consecutive cycles starting the cycle after done; tlast on 50 only; busy then falls.
//  T2 same C, tready toggled 1,0,0,1,0,1,1
//     -> tdata/tlast held through stalls; exactly 4 transfers in order; no beat lost or duplicated.
//  T3 second done (C={{-1,0},{0,-1}}) in the same cycle the last beat of T1 transfers
//     -> next cycle tvalid=1, tdata=0xFFFFFFFF; no IDLE gap; overrun=0.
//  T4 done during beat 2 with tready=0
//     -> overrun=1, stream still emits 19,22,43,50; err_clr pulse -> overrun=0.
//  T5 rst_n=0 for 1 cycle after beat 1
//     -> next cycle tvalid=0, busy=0, overrun=0; a following done streams a fresh matrix from C[0][0].
//  T6 RESULT_SAT_EN, OUT_W=16, C={{40000,-40000},{5,-5}}
//     -> beats 32767,-32768,5,-5; sat_flag=1.
//     Without the macro the same case gives 0x9C40,0x63C0,5,0xFFFB and sat_flag=0.

Source files
------------

// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer
//   Captures the ROWS x COLS signed result matrix C from the matmul core when
//   done pulses, then serialises it row-major onto an AXI4-Stream master, one
//   element per beat, with tlast on C[ROWS-1][COLS-1].
//
//   Optional feature macro: RESULT_SAT_EN
//     defined   : each element is saturated to the signed OUT_W range and
//                 sat_flag records (sticky) that a transferred beat was clamped
//     undefined : each element is truncated to its low OUT_W bits, sat_flag = 0
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   done, C         core result-valid pulse and result matrix (valid with done)
//   m_axis_*        AXI4-Stream master (tvalid/tready/tdata/tlast)
//   busy            a matrix is held or streaming
//   overrun         sticky: a done was dropped because we were busy
//   err_clr         clears overrun (and sat_flag when enabled)
//   sat_flag        sticky: an element was clamped on its way out
module matmul_result_streamer #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32,
  parameter int ROWS  = 2,
  parameter int COLS  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  done,
  input  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  C,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [OUT_W-1:0]                      m_axis_tdata,
  output logic                                  m_axis_tlast,
  output logic                                  busy,
  output logic                                  overrun,
  input  logic                                  err_clr,
  output logic                                  sat_flag
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               load;
  logic               xfer, last_xfer, ovr_set;
  logic [ACC_W-1:0]   hold [N];
  logic [ACC_W-1:0]   cur;
  logic [OUT_W-1:0]   cur_out;

  // Holding buffer, flattened row-major so idx addresses it directly.
  // Only written on an accepted capture, so C is don't-care otherwise.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          hold[r*COLS + c] <= C[r][c];
    end
  end

  assign cur = hold[idx_q];

`ifdef RESULT_SAT_EN
  logic cur_clamp;

  // The value fits OUT_W iff every bit from the OUT_W sign position upward
  // matches; otherwise clamp toward the sign of the full-width value.
  always_comb begin
    cur_clamp = !((&cur[ACC_W-1:OUT_W-1]) || !(|cur[ACC_W-1:OUT_W-1]));
    cur_out   = cur[OUT_W-1:0];
    if (cur_clamp)
      cur_out = cur[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                             : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 sat_flag <= 1'b0;
    else if (xfer && cur_clamp) sat_flag <= 1'b1;
    else if (err_clr)           sat_flag <= 1'b0;
  end
`else
  assign cur_out  = cur[OUT_W-1:0];
  assign sat_flag = 1'b0;
`endif

  // Next-state / control
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    xfer      = (state_q == STREAM) && m_axis_tready;
    last_xfer = xfer && (idx_q == LAST);
    // A done is only dropped when the last beat is not leaving this cycle.
    ovr_set   = done && (state_q == STREAM) && !last_xfer;
    case (state_q)
      IDLE: begin
        if (done) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          idx_d = '0;
          if (done) load    = 1'b1;   // back-to-back: no idle gap
          else      state_d = IDLE;
        end else if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they hold through stalls.
  always_comb begin
    m_axis_tvalid = (state_q == STREAM);
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    busy          = (state_q == STREAM);
    if (state_q == STREAM) begin
      m_axis_tdata = cur_out;
      m_axis_tlast = (idx_q == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (ovr_set)      overrun <= 1'b1;   // a new drop beats a clear
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_result_streamer.sv
module tb_matmul_result_streamer;

  logic clk = 1'b0;
  logic rst_n, done, tready, err_clr;
  logic [1:0][1:0][31:0] C;
  logic        tvalid, tlast, busy, overrun, sat_flag;
  logic [31:0] tdata;
  logic        v16, l16, b16, o16, s16;
  logic [15:0] d16;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  matmul_result_streamer dut (
    .clk(clk), .rst_n(rst_n), .done(done), .C(C),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .busy(busy), .overrun(overrun),
    .err_clr(err_clr), .sat_flag(sat_flag)
  );

  // Narrow-output instance sharing every input; exercises width reduction.
  matmul_result_streamer #(.ACC_W(32), .OUT_W(16), .ROWS(2), .COLS(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .done(done), .C(C),
    .m_axis_tvalid(v16), .m_axis_tready(tready), .m_axis_tdata(d16),
    .m_axis_tlast(l16), .busy(b16), .overrun(o16),
    .err_clr(err_clr), .sat_flag(s16)
  );

  // Reference element reduction to 16 bits, from the arithmetic definition.
  function automatic logic [15:0] elem16(input logic [31:0] x);
    int s;
    s = signed'(x);
`ifdef RESULT_SAT_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return x[15:0];
  endfunction

  function automatic bit clamp16(input logic [31:0] x);
`ifdef RESULT_SAT_EN
    int s;
    s = signed'(x);
    return (s > 32767) || (s < -32768);
`else
    return (x == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_c(input int a, input int b, input int c, input int d);
    C[0][0] = a; C[0][1] = b; C[1][0] = c; C[1][1] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done = 1'b0; tready = 1'b0; err_clr = 1'b0; set_c(0, 0, 0, 0);
    tick(); tick();
    checks++; if (tvalid !== 1'b0)   begin fails++; $display("FAIL reset_tvalid got %0b want 0", tvalid); end
    checks++; if (tlast !== 1'b0)    begin fails++; $display("FAIL reset_tlast got %0b want 0", tlast); end
    checks++; if (tdata !== 32'd0)   begin fails++; $display("FAIL reset_tdata got %0h want 0", tdata); end
    checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (overrun !== 1'b0)  begin fails++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    checks++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat got %0b want 0", sat_flag); end
    rst_n = 1'b1;
    tick();
  endtask

  // T1: full throughput, beats on consecutive cycles right after done.
  task automatic test_basic();
    logic [31:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    set_c(19, 22, 43, 50); done = 1'b1; tready = 1'b1;
    tick();
    done = 1'b0; set_c(-7, -7, -7, -7);   // C changes without done: no effect
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp[i] || tlast !== (i == 3) || busy !== 1'b1) begin
        fails++; $display("FAIL basic_beat%0d got v=%0b d=%0d l=%0b b=%0b want v=1 d=%0d l=%0b b=1",
                          i, tvalid, tdata, tlast, busy, exp[i], (i == 3));
      end
      tick();
    end
    checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_idle got v=%0b b=%0b want 0 0", tvalid, busy);
    end
  endtask

  // T2: stalls hold the beat; exactly four transfers in order.
  task automatic test_stall();
    logic [31:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int n = 0;
    set_c(19, 22, 43, 50); done = 1'b1; tready = 1'b1;
    tick();
    done = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tready = pat[k];
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp[n] || tlast !== (n == 3)) begin
        fails++; $display("FAIL stall_cyc%0d got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                          k, tvalid, tdata, tlast, exp[n], (n == 3));
      end
      if (pat[k]) n++;
      tick();
    end
    tready = 1'b1;
    checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL stall_end got v=%0b want 0", tvalid); end
  endtask

  // T3: new done coincides with the last beat transfer.
  task automatic test_back_to_back();
    logic [31:0] exp1 [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    logic [31:0] exp2 [4] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
    set_c(19, 22, 43, 50); done = 1'b1; tready = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tdata !== exp1[i] || tvalid !== 1'b1) begin
        fails++; $display("FAIL b2b_first%0d got %0d want %0d", i, tdata, exp1[i]);
      end
      if (i == 3) begin set_c(-1, 0, 0, -1); done = 1'b1; end
      tick();
      done = 1'b0;
    end
    checks++;
    if (tvalid !== 1'b1 || tdata !== 32'hFFFF_FFFF || overrun !== 1'b0) begin
      fails++; $display("FAIL b2b_gap got v=%0b d=%0h o=%0b want v=1 d=ffffffff o=0", tvalid, tdata, overrun);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp2[i] || tlast !== (i == 3)) begin
        fails++; $display("FAIL b2b_second%0d got d=%0h l=%0b want d=%0h l=%0b", i, tdata, tlast, exp2[i], (i == 3));
      end
      tick();
    end
    checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL b2b_end got v=%0b want 0", tvalid); end
  endtask

  // T4: done while busy is dropped and flagged; err_clr; set beats clear.
  task automatic test_overrun();
    logic [31:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    set_c(19, 22, 43, 50); done = 1'b1; tready = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (tdata !== exp[0]) begin fails++; $display("FAIL ovr_beat0 got %0d want 19", tdata); end
    tick();
    tready = 1'b0; set_c(99, 99, 99, 99); done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (overrun !== 1'b1 || tdata !== exp[1] || tlast !== 1'b0) begin
      fails++; $display("FAIL ovr_set got o=%0b d=%0d l=%0b want o=1 d=22 l=0", overrun, tdata, tlast);
    end
    tready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp[j] || tlast !== (j == 3)) begin
        fails++; $display("FAIL ovr_beat%0d got d=%0d l=%0b want d=%0d l=%0b", j, tdata, tlast, exp[j], (j == 3));
      end
      tick();
    end
    checks++; if (tvalid !== 1'b0 || overrun !== 1'b1) begin
      fails++; $display("FAIL ovr_hold got v=%0b o=%0b want v=0 o=1", tvalid, overrun);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clr got %0b want 0", overrun); end
    // Clear and a fresh drop in the same cycle: the drop wins.
    done = 1'b1; tick();
    done = 1'b1; err_clr = 1'b1; tick();
    done = 1'b0; err_clr = 1'b0;
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_setwins got %0b want 1", overrun); end
    repeat (3) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (overrun !== 1'b0 || tvalid !== 1'b0) begin
      fails++; $display("FAIL ovr_final got o=%0b v=%0b want 0 0", overrun, tvalid);
    end
  endtask

  // T5: reset mid-stream abandons the matrix; next done starts fresh.
  task automatic test_reset_mid();
    logic [31:0] exp [4] = '{32'd7, 32'd8, 32'd9, 32'd10};
    set_c(19, 22, 43, 50); done = 1'b1; tready = 1'b1;
    tick();
    tick();                 // beat 0 transferred, done also dropped -> overrun
    done = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || tlast !== 1'b0) begin
      fails++; $display("FAIL rstmid got v=%0b b=%0b o=%0b l=%0b want 0 0 0 0", tvalid, busy, overrun, tlast);
    end
    set_c(7, 8, 9, 10); done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp[i] || tlast !== (i == 3)) begin
        fails++; $display("FAIL rstmid_beat%0d got d=%0d l=%0b want d=%0d l=%0b", i, tdata, tlast, exp[i], (i == 3));
      end
      tick();
    end
  endtask

  // T6: width reduction on the 16-bit instance.
  task automatic test_sat();
    logic [31:0] src [4] = '{32'd40000, -32'sd40000, 32'd5, -32'sd5};
    set_c(40000, -40000, 5, -5); done = 1'b1; tready = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (v16 !== 1'b1 || d16 !== elem16(src[i]) || l16 !== (i == 3)) begin
        fails++; $display("FAIL sat_beat%0d got d=%0h l=%0b want d=%0h l=%0b", i, d16, l16, elem16(src[i]), (i == 3));
      end
      checks++;
      if (tdata !== src[i]) begin
        fails++; $display("FAIL sat_wide%0d got %0h want %0h", i, tdata, src[i]);
      end
      tick();
    end
`ifdef RESULT_SAT_EN
    checks++; if (s16 !== 1'b1) begin fails++; $display("FAIL sat_flag16 got %0b want 1", s16); end
`else
    checks++; if (s16 !== 1'b0) begin fails++; $display("FAIL sat_flag16 got %0b want 0", s16); end
`endif
    checks++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL sat_flag32 got %0b want 0", sat_flag); end
  endtask

  // Randomised traffic against a matrix-level scoreboard.
  task automatic test_random();
    logic [31:0] q [4];
    bit act = 0, exp_ovr = 0, exp_sat = 0;
    bit xf, lst, dn, ec;
    int pos = 0;
    rst_n = 1'b0; done = 1'b0; err_clr = 1'b0; tick(); rst_n = 1'b1;
    for (int cyc = 0; cyc < 420; cyc++) begin
      bit drain;
      drain = (cyc >= 400);
      checks++;
      if (tvalid !== act || v16 !== act) begin
        fails++; $display("FAIL rnd_valid cyc%0d got %0b/%0b want %0b", cyc, tvalid, v16, act);
      end
      if (act) begin
        checks++;
        if (tdata !== q[pos] || tlast !== (pos == 3) || d16 !== elem16(q[pos]) || l16 !== (pos == 3)) begin
          fails++; $display("FAIL rnd_beat cyc%0d got d=%0h l=%0b d16=%0h want d=%0h l=%0b d16=%0h",
                            cyc, tdata, tlast, d16, q[pos], (pos == 3), elem16(q[pos]));
        end
      end
      tready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      dn = drain ? 1'b0 : (act ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) == 0));
      ec = (!tready && !dn && $urandom_range(0, 3) == 0);
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          C[r][c] = $urandom;
      done = dn; err_clr = ec;
      xf  = act && tready;
      lst = xf && (pos == 3);
      if (xf && clamp16(q[pos])) exp_sat = 1;
      if (ec) exp_sat = 0;
      if (dn && act && !lst) exp_ovr = 1;
      else if (ec)           exp_ovr = 0;
      if (!act) begin
        if (dn) begin
          q = '{C[0][0], C[0][1], C[1][0], C[1][1]};
          act = 1; pos = 0;
        end
      end else if (xf) begin
        if (lst) begin
          pos = 0;
          if (dn) q = '{C[0][0], C[0][1], C[1][0], C[1][1]};
          else    act = 0;
        end else pos++;
      end
      tick();
      done = 1'b0; err_clr = 1'b0;
      checks++;
      if (overrun !== exp_ovr || o16 !== exp_ovr || s16 !== exp_sat) begin
        fails++; $display("FAIL rnd_flags cyc%0d got o=%0b o16=%0b s16=%0b want o=%0b s16=%0b",
                          cyc, overrun, o16, s16, exp_ovr, exp_sat);
      end
    end
    checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL rnd_drain got v=%0b want 0", tvalid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
